// File: rtl/plot_pkg.sv
// Shared screen geometry and sequencer state encoding for the plot path.
package plot_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    RUN,
    REL,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/plot_clip.sv
// Registered selection of the granted engine's plot stream onto the VGA port,
// with off-screen pixels dropped rather than wrapped.
module plot_clip
  import plot_pkg::*;
#(
  parameter int NUM_ENG = 3,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int IDX_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IDX_W-1:0]             idx,
  input  logic                         in_run,
  input  logic [NUM_ENG*X_W-1:0]       eng_x,
  input  logic [NUM_ENG*Y_W-1:0]       eng_y,
  input  logic [NUM_ENG*COLOUR_W-1:0]  eng_colour,
  input  logic [NUM_ENG-1:0]           eng_plot,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot
);

  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;
  logic                sel_plot;
  logic                on_screen;

  // Mux the granted slot; an out-of-range index selects nothing.
  always_comb begin
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    sel_plot     = 1'b0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      if (idx == IDX_W'(i)) begin
        vga_x_d      = eng_x[i*X_W +: X_W];
        vga_y_d      = eng_y[i*Y_W +: Y_W];
        vga_colour_d = eng_colour[i*COLOUR_W +: COLOUR_W];
        sel_plot     = eng_plot[i];
      end
    end
    on_screen  = (int'(vga_x_d) < SCREEN_W) && (int'(vga_y_d) < SCREEN_H);
    vga_plot_d = sel_plot & in_run & on_screen;
  end

  // One-cycle output register toward the adapter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: rtl/plot_sequencer.sv
// Runs the enabled drawing engines one at a time in slot order and forwards
// the granted engine's plot stream to the VGA adapter.
module plot_sequencer
  import plot_pkg::*;
#(
  parameter int NUM_ENG = 3,
  parameter int X_W     = 8,
  parameter int Y_W     = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         done,
  input  logic [NUM_ENG-1:0]           eng_en,
  output logic [NUM_ENG-1:0]           eng_start,
  input  logic [NUM_ENG-1:0]           eng_done,
  input  logic [NUM_ENG*X_W-1:0]       eng_x,
  input  logic [NUM_ENG*Y_W-1:0]       eng_y,
  input  logic [NUM_ENG*COLOUR_W-1:0]  eng_colour,
  input  logic [NUM_ENG-1:0]           eng_plot,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic [2:0]                   cur_eng
);

  localparam int                IDX_W   = $clog2(NUM_ENG + 1);
  localparam logic [IDX_W-1:0]  IDX_END = IDX_W'(NUM_ENG);

  seq_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_ENG-1:0] en_q, en_d;
  logic               slot_en;
  logic               slot_done;
  logic               in_run;

  // Per-slot enable and done of the slot currently addressed by idx.
  always_comb begin
    slot_en   = 1'b0;
    slot_done = 1'b0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slot_en   = en_q[i];
        slot_done = eng_done[i];
      end
    end
  end

  // Next-state logic: scan, run, release each slot; start low aborts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          en_d    = eng_en;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!start)                 state_d = IDLE;
        else if (idx_q == IDX_END)  state_d = FINISH;
        else if (!slot_en)          idx_d   = idx_q + 1'b1;
        else                        state_d = RUN;
      end
      RUN: begin
        if (!start)         state_d = IDLE;
        else if (slot_done) state_d = REL;
      end
      REL: begin
        if (!start) begin
          state_d = IDLE;
        end else if (!slot_done) begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end
      end
      FINISH: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, slot index and latched enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
    end
  end

  // Decoded outputs; in_run also requires start so an abort blanks vga_plot
  // on the very edge the FSM returns to IDLE.
  always_comb begin
    eng_start = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      eng_start[i] = (state_q == RUN) && (idx_q == IDX_W'(i));
    end
    done    = (state_q == FINISH);
    in_run  = ((state_q == RUN) || (state_q == REL)) && start;
    cur_eng = ((state_q == SCAN) || (state_q == RUN) || (state_q == REL)) ? 3'(idx_q) : '0;
  end

  plot_clip #(
    .NUM_ENG (NUM_ENG),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .IDX_W   (IDX_W)
  ) u_clip (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (idx_q),
    .in_run     (in_run),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_colour (eng_colour),
    .eng_plot   (eng_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

endmodule

// File: tb/tb_plot_sequencer.sv
// Bench for plot_sequencer: engine BFMs, plot scoreboard, scenario tasks.
module tb_plot_sequencer;

  localparam int NUM_ENG = 3;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   done;
  logic [NUM_ENG-1:0]     eng_en;
  logic [NUM_ENG-1:0]     eng_start;
  logic [NUM_ENG-1:0]     eng_done;
  logic [NUM_ENG*X_W-1:0] eng_x;
  logic [NUM_ENG*Y_W-1:0] eng_y;
  logic [NUM_ENG*3-1:0]   eng_colour;
  logic [NUM_ENG-1:0]     eng_plot;
  logic [X_W-1:0]         vga_x;
  logic [Y_W-1:0]         vga_y;
  logic [2:0]             vga_colour;
  logic                   vga_plot;
  logic [2:0]             cur_eng;

  plot_sequencer #(.NUM_ENG(NUM_ENG), .X_W(X_W), .Y_W(Y_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .eng_en(eng_en), .eng_start(eng_start), .eng_done(eng_done),
    .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour), .eng_plot(eng_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .cur_eng(cur_eng)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; int stamp; } exp_t;
  exp_t sb[$];
  int   order[$];
  int   cur_trace[$];
  int   total = 0;
  int   bad   = 0;
  int   plots = 0;
  int   cyc   = 0;

  int ph  [NUM_ENG];
  int kk  [NUM_ENG];
  int npx [NUM_ENG];
  int px_x[NUM_ENG][32];
  int px_y[NUM_ENG][32];
  int px_c[NUM_ENG][32];

  // Engine BFMs: drive after each posedge, predict accepted plots just before the next one.
  initial begin
    eng_done = '0; eng_plot = '0; eng_x = '0; eng_y = '0; eng_colour = '0;
    for (int i = 0; i < NUM_ENG; i++) begin ph[i] = 0; kk[i] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NUM_ENG; i++) begin
        case (ph[i])
          0: begin
            eng_plot[i] = 1'b0; eng_done[i] = 1'b0;
            if (eng_start[i]) begin ph[i] = 1; kk[i] = 0; order.push_back(i); end
          end
          1: begin
            if (!eng_start[i]) begin
              ph[i] = 0; eng_plot[i] = 1'b0; eng_done[i] = 1'b0;
            end else if (kk[i] < npx[i]) begin
              eng_plot[i] = 1'b1;
              eng_x[i*X_W +: X_W]    = X_W'(px_x[i][kk[i]]);
              eng_y[i*Y_W +: Y_W]    = Y_W'(px_y[i][kk[i]]);
              eng_colour[i*3 +: 3]   = 3'(px_c[i][kk[i]]);
              kk[i]++;
            end else begin
              eng_plot[i] = 1'b0; eng_done[i] = 1'b1; ph[i] = 2;
            end
          end
          default: begin
            if (!eng_start[i]) begin eng_done[i] = 1'b0; ph[i] = 0; end
          end
        endcase
      end
      @(negedge clk);
      #4;
      for (int i = 0; i < NUM_ENG; i++) begin
        int x, y;
        x = int'(eng_x[i*X_W +: X_W]);
        y = int'(eng_y[i*Y_W +: Y_W]);
        if (rst_n && start && eng_start[i] && eng_plot[i] && x < 160 && y < 120)
          sb.push_back('{x: x, y: y, c: int'(eng_colour[i*3 +: 3]), stamp: cyc + 1});
      end
    end
  end

  // Output monitor: scoreboard pops, grant one-hot and cur_eng tracking.
  initial begin
    forever begin
      @(negedge clk);
      if (vga_plot === 1'b1) begin
        plots++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, expected no plot", vga_x, vga_y, vga_colour);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (vga_x !== X_W'(e.x) || vga_y !== Y_W'(e.y) || vga_colour !== 3'(e.c) || cyc != e.stamp) begin
            bad++;
            $display("FAIL plot_data: got x=%0d y=%0d c=%0d cyc=%0d, expected x=%0d y=%0d c=%0d cyc=%0d",
                     vga_x, vga_y, vga_colour, cyc, e.x, e.y, e.c, e.stamp);
          end
        end
      end
      if (eng_start !== '0) begin
        int idx;
        idx = 0;
        for (int i = 0; i < NUM_ENG; i++) if (eng_start[i]) idx = i;
        total++;
        if ($countones(eng_start) != 1 || cur_eng !== 3'(idx)) begin
          bad++;
          $display("FAIL grant: eng_start=%b cur_eng=%0d, expected one-hot with cur_eng=%0d", eng_start, cur_eng, idx);
        end
        if (cur_trace.size() == 0 || cur_trace[$] != int'(cur_eng)) cur_trace.push_back(int'(cur_eng));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit hit, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic std_pixels();
    for (int i = 0; i < NUM_ENG; i++) begin
      npx[i] = 4;
      for (int k = 0; k < 4; k++) begin
        px_x[i][k] = 10 * i + k + 1;
        px_y[i][k] = 5 * i + k + 2;
        px_c[i][k] = (i + k + 1) % 8;
      end
    end
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, expected 1", name, done, n);
    end
  endtask

  task automatic finish_seq();
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_clear: done=%b, expected 0", done); end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; eng_en = '0;
    for (int i = 0; i < NUM_ENG; i++) npx[i] = 0;
    repeat (2) tick();
    total++;
    if (done !== 1'b0 || eng_start !== '0 || vga_plot !== 1'b0 || vga_x !== '0 ||
        vga_y !== '0 || vga_colour !== '0 || cur_eng !== '0) begin
      bad++;
      $display("FAIL reset_state: done=%b start=%b plot=%b x=%0d y=%0d c=%0d cur=%0d, expected all 0",
               done, eng_start, vga_plot, vga_x, vga_y, vga_colour, cur_eng);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_engines();
    std_pixels();
    order.delete(); plots = 0;
    eng_en = 3'b111; start = 1'b1;
    run_until_done(300, "all");
    total++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
      bad++; $display("FAIL all_order: got %p, expected '{0,1,2}", order);
    end
    total++;
    if (plots != 12 || sb.size() != 0) begin
      bad++; $display("FAIL all_plots: plots=%0d pending=%0d, expected 12 and 0", plots, sb.size());
    end
    repeat (3) tick();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL done_hold: done=%b, expected 1", done); end
    finish_seq();
  endtask

  task automatic test_skip();
    std_pixels();
    order.delete(); cur_trace.delete(); plots = 0;
    eng_en = 3'b101; start = 1'b1;
    run_until_done(300, "skip");
    total++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 2) begin
      bad++; $display("FAIL skip_order: got %p, expected '{0,2}", order);
    end
    total++;
    if (cur_trace.size() != 2 || cur_trace[0] != 0 || cur_trace[1] != 2) begin
      bad++; $display("FAIL skip_cur_eng: got %p, expected '{0,2}", cur_trace);
    end
    total++;
    if (plots != 8) begin bad++; $display("FAIL skip_plots: plots=%0d, expected 8", plots); end
    finish_seq();
  endtask

  task automatic test_clip();
    std_pixels();
    npx[0] = 3;
    px_x[0][0] = 160; px_y[0][0] = 5;   px_c[0][0] = 1;
    px_x[0][1] = 3;   px_y[0][1] = 120; px_c[0][1] = 2;
    px_x[0][2] = 159; px_y[0][2] = 119; px_c[0][2] = 5;
    order.delete(); plots = 0;
    eng_en = 3'b001; start = 1'b1;
    run_until_done(200, "clip");
    total++;
    if (plots != 1 || sb.size() != 0) begin
      bad++; $display("FAIL clip_plots: plots=%0d pending=%0d, expected 1 and 0", plots, sb.size());
    end
    finish_seq();
  endtask

  task automatic test_abort();
    int n;
    int seen_done;
    std_pixels();
    npx[1] = 20;
    for (int k = 0; k < 20; k++) begin px_x[1][k] = 40 + k; px_y[1][k] = 30; px_c[1][k] = 6; end
    order.delete(); plots = 0;
    eng_en = 3'b111; start = 1'b1;
    n = 0;
    while (eng_start[1] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (eng_start[1] !== 1'b1) begin bad++; $display("FAIL abort_wait: eng_start=%b, expected slot 1 running", eng_start); end
    repeat (3) @(negedge clk);
    #1 start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (eng_start !== '0) begin bad++; $display("FAIL abort_start: eng_start=%b, expected 0", eng_start); end
    @(negedge clk);
    total++;
    if (vga_plot !== 1'b0 || cur_eng !== '0) begin
      bad++; $display("FAIL abort_idle: vga_plot=%b cur_eng=%0d, expected 0 and 0", vga_plot, cur_eng);
    end
    seen_done = 0;
    repeat (6) begin tick(); if (done === 1'b1) seen_done++; end
    total++;
    if (seen_done != 0 || order.size() != 2 || sb.size() != 0) begin
      bad++; $display("FAIL abort_after: done_cycles=%0d order=%p pending=%0d, expected 0, '{0,1}, 0",
                      seen_done, order, sb.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    std_pixels();
    order.delete(); plots = 0;
    eng_en = 3'b111; start = 1'b1;
    n = 0;
    while (eng_start[2] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || eng_start !== '0 || vga_plot !== 1'b0 || vga_x !== '0 ||
        vga_y !== '0 || vga_colour !== '0 || cur_eng !== '0) begin
      bad++;
      $display("FAIL midreset_state: done=%b start=%b plot=%b x=%0d y=%0d c=%0d cur=%0d, expected all 0",
               done, eng_start, vga_plot, vga_x, vga_y, vga_colour, cur_eng);
    end
    start = 1'b0;
    repeat (2) tick();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL midreset_pending: pending=%0d, expected 0", sb.size()); end
    rst_n = 1'b1;
    tick();
    order.delete(); plots = 0;
    start = 1'b1;
    run_until_done(300, "restart");
    total++;
    if (plots != 12 || order.size() != 3) begin
      bad++; $display("FAIL restart_run: plots=%0d starts=%0d, expected 12 and 3", plots, order.size());
    end
    finish_seq();
  endtask

  task automatic test_all_disabled();
    int n;
    eng_en = '0;
    order.delete();
    start = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (done === 1'b1) break;
    end
    total++;
    if (done !== 1'b1 || n != NUM_ENG + 2) begin
      bad++; $display("FAIL disabled_latency: done=%b at cycle %0d, expected 1 at cycle %0d", done, n, NUM_ENG + 2);
    end
    total++;
    if (order.size() != 0) begin bad++; $display("FAIL disabled_starts: got %0d starts, expected 0", order.size()); end
    tick();
    finish_seq();
  endtask

  initial begin
    test_reset();
    test_all_engines();
    test_skip();
    test_clip();
    test_abort();
    test_reset_mid_run();
    test_all_disabled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
